// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter in front of one pipelined memory port.
// A port keeps the grant for up to BURST back-to-back transfers while the
// other port waits. Accepted requests are registered onto the memory side.
// Each read is tracked by a MEM_LAT-deep tag pipeline, so the response
// returns to the port that issued it.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int BURST   = 4
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [2:0]  r0_op,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [2:0]  r1_op,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_op,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  // Arbitration state. The reset values (owner 1, count saturated) make the
  // first contention after reset go to port 0.
  logic              last_owner_r;
  logic [3:0]        cnt_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              xfer_s;

  // Registered memory request and the owner of the request now on the bus.
  logic              m_en_r;
  logic              m_we_r;
  logic [31:0]       m_addr_r;
  logic [31:0]       m_wdata_r;
  logic [2:0]        m_op_r;
  logic              m_owner_r;

  // Read tag pipeline: stage MEM_LAT-1 lines up with valid m_rdata.
  logic [MEM_LAT-1:0] tag_v_r;
  logic [MEM_LAT-1:0] tag_o_r;

  // Grant decision: a lone requester always wins. Under contention the current
  // owner keeps the grant until its burst count reaches BURST.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!clrn) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({r1_req, r0_req})
        2'b01: gnt0_s = 1'b1;
        2'b10: gnt1_s = 1'b1;
        2'b11: begin
          if (cnt_r < BURST_C) begin
            gnt0_s = ~last_owner_r;
            gnt1_s = last_owner_r;
          end else begin
            gnt0_s = last_owner_r;
            gnt1_s = ~last_owner_r;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign xfer_s = gnt0_s | gnt1_s;

  // Burst bookkeeping. The count also advances when the port is alone, so a
  // long solo stream gives up the grant as soon as the other port competes.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      last_owner_r <= 1'b1;
      cnt_r        <= BURST_C;
    end else if (xfer_s) begin
      if (gnt1_s == last_owner_r) begin
        cnt_r <= (cnt_r >= BURST_C) ? BURST_C : cnt_r + 4'd1;
      end else begin
        last_owner_r <= gnt1_s;
        cnt_r        <= 4'd1;
      end
    end
  end

  // Capture the granted request onto the memory bus. The address, data and op
  // hold their last values when idle; we drops to 0 so an idle bus looks like
  // a read.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_en_r    <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= 32'd0;
      m_wdata_r <= 32'd0;
      m_op_r    <= 3'd0;
      m_owner_r <= 1'b0;
    end else if (xfer_s) begin
      m_en_r    <= 1'b1;
      m_we_r    <= gnt1_s ? r1_we    : r0_we;
      m_addr_r  <= gnt1_s ? r1_addr  : r0_addr;
      m_wdata_r <= gnt1_s ? r1_wdata : r0_wdata;
      m_op_r    <= gnt1_s ? r1_op    : r0_op;
      m_owner_r <= gnt1_s;
    end else begin
      m_en_r <= 1'b0;
      m_we_r <= 1'b0;
    end
  end

  // Shift read tags toward the response cycle. Writes enter as empty slots.
  // Reset flushes every read still in flight.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      tag_v_r <= '0;
      tag_o_r <= '0;
    end else begin
      tag_v_r[0] <= m_en_r & ~m_we_r;
      tag_o_r[0] <= m_owner_r;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v_r[i] <= tag_v_r[i-1];
        tag_o_r[i] <= tag_o_r[i-1];
      end
    end
  end

  assign r0_gnt    = gnt0_s;
  assign r1_gnt    = gnt1_s;
  assign r0_rvalid = tag_v_r[MEM_LAT-1] & ~tag_o_r[MEM_LAT-1];
  assign r1_rvalid = tag_v_r[MEM_LAT-1] &  tag_o_r[MEM_LAT-1];
  assign r0_rdata  = m_rdata;
  assign r1_rdata  = m_rdata;
  assign m_en      = m_en_r;
  assign m_we      = m_we_r;
  assign m_addr    = m_addr_r;
  assign m_wdata   = m_wdata_r;
  assign m_op      = m_op_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3, BURST=4) share
// the same stimulus. A reference model built from the arbitration rules
// predicts grants, the memory-side request and the cycle/owner of each read
// response. Memory data is a hash of the cycle number.
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int BURST = 4;

  logic        clock, clrn;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, m_rdata;
  logic [2:0]  r0_op, r1_op;

  logic        r0_gnt_a, r1_gnt_a, r0_rvalid_a, r1_rvalid_a, m_en_a, m_we_a;
  logic [31:0] r0_rdata_a, r1_rdata_a, m_addr_a, m_wdata_a;
  logic [2:0]  m_op_a;
  logic        r0_gnt_b, r1_gnt_b, r0_rvalid_b, r1_rvalid_b, m_en_b, m_we_b;
  logic [31:0] r0_rdata_b, r1_rdata_b, m_addr_b, m_wdata_b;
  logic [2:0]  m_op_b;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .BURST(BURST)) dut_a (
    .clock(clock), .clrn(clrn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_op(r0_op),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_op(r1_op),
    .r0_gnt(r0_gnt_a), .r1_gnt(r1_gnt_a),
    .r0_rvalid(r0_rvalid_a), .r0_rdata(r0_rdata_a),
    .r1_rvalid(r1_rvalid_a), .r1_rdata(r1_rdata_a),
    .m_en(m_en_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a), .m_op(m_op_a),
    .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(LAT_B), .BURST(BURST)) dut_b (
    .clock(clock), .clrn(clrn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_op(r0_op),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_op(r1_op),
    .r0_gnt(r0_gnt_b), .r1_gnt(r1_gnt_b),
    .r0_rvalid(r0_rvalid_b), .r0_rdata(r0_rdata_b),
    .r1_rvalid(r1_rvalid_b), .r1_rdata(r1_rdata_b),
    .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_op(m_op_b),
    .m_rdata(m_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks, failures, cyc;
  int          mdl_last, mdl_cnt;
  logic        exp_en, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [2:0]  exp_op;
  int          pend_a [4096];
  int          pend_b [4096];

  function automatic logic [31:0] hash(input int c);
    return (32'(c) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ev_a, ev_b;
    ev_a = {pend_a[cyc] == 1, pend_a[cyc] == 0};
    ev_b = {pend_b[cyc] == 1, pend_b[cyc] == 0};
    chk("a_ctl",    {27'd0, m_op_a, m_we_a, m_en_a}, {27'd0, exp_op, exp_we, exp_en});
    chk("a_addr",   m_addr_a, exp_addr);
    chk("a_wdata",  m_wdata_a, exp_wdata);
    chk("a_rvalid", {30'd0, r1_rvalid_a, r0_rvalid_a}, {30'd0, ev_a});
    chk("a_rdata",  r0_rdata_a ^ r1_rdata_a ^ r0_rdata_a, hash(cyc));
    chk("b_ctl",    {27'd0, m_op_b, m_we_b, m_en_b}, {27'd0, exp_op, exp_we, exp_en});
    chk("b_addr",   m_addr_b, exp_addr);
    chk("b_wdata",  m_wdata_b, exp_wdata);
    chk("b_rvalid", {30'd0, r1_rvalid_b, r0_rvalid_b}, {30'd0, ev_b});
    chk("b_rdata0", r0_rdata_b, hash(cyc));
    chk("b_rdata1", r1_rdata_a & r1_rdata_b, hash(cyc));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
    m_rdata = hash(cyc);
    #1;
    check_outputs();
  endtask

  // Present one request pair before the edge, check grants, advance the model.
  task automatic step(input logic q0, input logic w0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic [2:0] o0,
                      input logic q1, input logic w1, input logic [31:0] a1,
                      input logic [31:0] d1, input logic [2:0] o1,
                      output logic [1:0] g_obs);
    int g;
    logic [1:0] exp_g;
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0; r0_op = o0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1; r1_op = o1;
    #1;
    g = -1;
    if (q0 && !q1) g = 0;
    else if (q1 && !q0) g = 1;
    else if (q0 && q1) g = (mdl_cnt < BURST) ? mdl_last : 1 - mdl_last;
    exp_g = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    g_obs = {r1_gnt_a, r0_gnt_a};
    chk("gnt_a", {30'd0, g_obs}, {30'd0, exp_g});
    chk("gnt_b", {30'd0, r1_gnt_b, r0_gnt_b}, {30'd0, exp_g});
    if (g >= 0) begin
      if (g == mdl_last) mdl_cnt = (mdl_cnt < BURST) ? mdl_cnt + 1 : BURST;
      else begin mdl_last = g; mdl_cnt = 1; end
      exp_en    = 1'b1;
      exp_we    = (g == 1) ? w1 : w0;
      exp_addr  = (g == 1) ? a1 : a0;
      exp_wdata = (g == 1) ? d1 : d0;
      exp_op    = (g == 1) ? o1 : o0;
      if (!exp_we) begin
        pend_a[cyc + 1 + LAT_A] = g;
        pend_b[cyc + 1 + LAT_B] = g;
      end
    end else begin
      exp_en = 1'b0;
      exp_we = 1'b0;
    end
    next_cycle();
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    repeat (n) step(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, g);
  endtask

  // Assert reset mid-cycle with both reqs high; everything must drop at once.
  task automatic do_reset(input int n);
    clrn = 1'b0;
    r0_req = 1'b1;
    r1_req = 1'b1;
    #1;
    mdl_last = 1; mdl_cnt = BURST;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_op = 3'd0;
    for (int i = 0; i < 8; i++) begin
      pend_a[cyc + i] = -1;
      pend_b[cyc + i] = -1;
    end
    check_outputs();
    chk("rst_gnt", {30'd0, r1_gnt_b, r0_gnt_b, r1_gnt_a, r0_gnt_a} , 32'd0);
    repeat (n) next_cycle();
    @(negedge clock);
    r0_req = 1'b0;
    r1_req = 1'b0;
    clrn = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [1:0] g;
    logic       q0, q1;
    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 4096; i++) begin
      pend_a[i] = -1;
      pend_b[i] = -1;
    end
    clrn = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0; r0_op = 3'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0; r1_op = 3'd0;
    m_rdata = hash(0);
    #7;
    do_reset(2);

    // Single read from port 0.
    step(1'b1, 1'b0, 32'h100, 32'd0, 3'd2, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, g);
    idle(4);

    // Contention straight after reset: 0,0,0,0,1,1,1,1,0.
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 32'h1000 + 32'(i), 32'd0, 3'd1,
           1'b1, 1'b0, 32'h2000 + 32'(i), 32'd0, 3'd3, g);
      chk("contention_seq", {30'd0, g}, (i < 4 || i == 8) ? 32'd1 : 32'd2);
    end
    idle(4);

    // Mixed stream: r0 writes 0x5 to 0x200, r1 reads 0x200, alternating.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b1, 32'h200, 32'h5, 3'd4, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, g);
      else            step(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 32'h200, 32'd0, 3'd5, g);
    end
    idle(4);

    // Three back-to-back r1 reads, response spacing checked on both latencies.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'd0, 3'd6, g);
    idle(5);

    // Mid-flight reset one cycle after a read issue.
    step(1'b1, 1'b0, 32'h400, 32'd0, 3'd7, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, g);
    do_reset(2);
    idle(4);
    step(1'b1, 1'b0, 32'h500, 32'd0, 3'd0, 1'b1, 1'b0, 32'h600, 32'd0, 3'd0, g);
    chk("post_reset_first", {30'd0, g}, 32'd1);
    idle(4);

    // Single requester: ten uninterrupted r1 grants.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 1'($urandom_range(0, 1)),
           $urandom, $urandom, 3'($urandom_range(0, 7)), g);
      chk("solo_r1", {30'd0, g}, 32'd2);
    end
    idle(4);

    // Randomised traffic, with one reset in the middle.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset(1);
      q0 = ($urandom_range(0, 3) != 0);
      q1 = ($urandom_range(0, 3) != 0);
      step(q0, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
           q1, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)), g);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
